// File: rtl/ccg_lut_eval_pipe.sv
// Run-time reprogrammable N_IN-input LUT bank evaluated through a 2-stage valid/ready pipeline.
// Optional build macro CCG_LUT_PARITY_EN: adds an even-parity bit to f and rejects constant tables.
module ccg_lut_eval_pipe #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 15,
  parameter int unsigned CNT_W = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cfg_we,
  input  logic [$clog2(N_OUT > 1 ? N_OUT : 2)-1:0] cfg_idx,
  input  logic [2**N_IN-1:0]                     cfg_data,
  output logic                                   cfg_ack,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [N_IN-1:0]                        x,
  output logic                                   out_valid,
  input  logic                                   out_ready,
`ifdef CCG_LUT_PARITY_EN
  output logic [N_OUT:0]                         f,
`else
  output logic [N_OUT-1:0]                       f,
`endif
  output logic [CNT_W-1:0]                       eval_cnt,
  output logic                                   busy
);

  localparam int unsigned DEPTH = 2**N_IN;
  localparam int unsigned IDX_W = $clog2(N_OUT > 1 ? N_OUT : 2);
`ifdef CCG_LUT_PARITY_EN
  localparam int unsigned F_W = N_OUT + 1;
`else
  localparam int unsigned F_W = N_OUT;
`endif

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_WRITE
  } state_t;

  state_t            state, state_nxt;
  logic [DEPTH-1:0]  lut [N_OUT];
  logic [IDX_W-1:0]  idx_q;
  logic [DEPTH-1:0]  data_q;
  logic              s1_v, s2_v;
  logic [N_IN-1:0]   s1_x;
  logic [N_OUT-1:0]  eval_f;
  logic [F_W-1:0]    f_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              s2_adv, s1_adv, accept, out_hs, idx_ok, lut_wr;

  assign s2_adv    = !s2_v || out_ready;
  assign s1_adv    = !s1_v || s2_adv;
  assign in_ready  = s1_adv && (state == ST_RUN) && !cfg_we;
  assign accept    = in_valid && in_ready;
  assign out_hs    = s2_v && out_ready;
  assign out_valid = s2_v;
  assign f         = f_q;
  assign busy      = (state != ST_RUN);
  assign idx_ok    = {{(32-IDX_W){1'b0}}, idx_q} < N_OUT;

`ifdef CCG_LUT_PARITY_EN
  logic data_const, rej_q;
  assign data_const = (data_q == '0) || (data_q == '1);
  assign eval_cnt   = cnt_q | {rej_q, {(CNT_W-1){1'b0}}};
`else
  assign eval_cnt   = cnt_q;
`endif

  always_comb begin
    state_nxt = state;
    cfg_ack   = 1'b0;
    lut_wr    = 1'b0;
    case (state)
      ST_RUN:   if (cfg_we) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!s1_v && !s2_v) state_nxt = ST_WRITE;
      ST_WRITE: begin
        cfg_ack   = 1'b1;
`ifdef CCG_LUT_PARITY_EN
        lut_wr    = idx_ok && !data_const;
`else
        lut_wr    = idx_ok;
`endif
        state_nxt = ST_RUN;
      end
      default:  state_nxt = ST_RUN;
    endcase
  end

  // Request fields are captured on the RUN->DRAIN edge so the requester may change them afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_RUN && cfg_we) begin
        idx_q  <= cfg_idx;
        data_q <= cfg_data;
      end
    end
  end

  // Reset table for LUT j is a buffer of x[j % N_IN].
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned j = 0; j < N_OUT; j++)
        for (int unsigned k = 0; k < DEPTH; k++)
          lut[j][k] <= k[j % N_IN];
    end else if (lut_wr) begin
      lut[idx_q] <= data_q;
    end
  end

  always_comb begin
    eval_f = '0;
    for (int unsigned j = 0; j < N_OUT; j++)
      eval_f[j] = lut[j][s1_x];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_x <= '0;
      f_q  <= '0;
    end else begin
      if (s1_adv) begin
        s1_v <= accept;
        if (accept) s1_x <= x;
      end
      if (s2_adv) begin
        s2_v <= s1_v;
`ifdef CCG_LUT_PARITY_EN
        if (s1_v) f_q <= {^eval_f, eval_f};
`else
        if (s1_v) f_q <= eval_f;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_hs && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef CCG_LUT_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rej_q <= 1'b0;
    end else if (state == ST_WRITE && idx_ok && data_const) begin
      rej_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ccg_lut_eval_pipe.sv
// Bench for ccg_lut_eval_pipe: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model (expected-output queue, table array, handshake count).
module tb_ccg_lut_eval_pipe;

  localparam int N_OUT = 15;
`ifdef CCG_LUT_PARITY_EN
  localparam int F_W = N_OUT + 1;
`else
  localparam int F_W = N_OUT;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_we = 1'b0;
  logic [3:0]     cfg_idx = '0;
  logic [15:0]    cfg_data = '0;
  logic           in_valid = 1'b0;
  logic [3:0]     x = '0;
  logic           out_ready = 1'b1;

  logic           cfg_ack, in_ready, out_valid, busy;
  logic [F_W-1:0] f;
  logic [15:0]    eval_cnt;
  logic           s_cfg_ack, s_in_ready, s_out_valid, s_busy;
  logic [F_W-1:0] s_f;
  logic [3:0]     s_eval_cnt;

  always #5 clk = ~clk;

  ccg_lut_eval_pipe #(.N_IN(4), .N_OUT(N_OUT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .cfg_ack(cfg_ack), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .f(f), .eval_cnt(eval_cnt), .busy(busy)
  );

  ccg_lut_eval_pipe #(.N_IN(4), .N_OUT(N_OUT), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .cfg_ack(s_cfg_ack), .in_valid(in_valid), .in_ready(s_in_ready), .x(x),
    .out_valid(s_out_valid), .out_ready(out_ready), .f(s_f), .eval_cnt(s_eval_cnt), .busy(s_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0]    mlut [N_OUT];
  logic [F_W-1:0] qf [$];
  int             qs [$];
  int             cyc = 0;
  int             hs = 0;
  int             phase = 0;      // 0 idle, 1 waiting for pipeline empty, 2 ack cycle
  logic [3:0]     lat_idx;
  logic [15:0]    lat_data;
  logic           sticky = 1'b0;
  logic           armed = 1'b0;

  function automatic logic [F_W-1:0] model_eval(input logic [3:0] xv);
    logic [F_W-1:0] r;
    r = '0;
    for (int j = 0; j < N_OUT; j++) r[j] = mlut[j][xv];
`ifdef CCG_LUT_PARITY_EN
    r[N_OUT] = ^r[N_OUT-1:0];
`endif
    return r;
  endfunction

  task automatic model_reset();
    logic [15:0] pat [4];
    pat = '{16'hAAAA, 16'hCCCC, 16'hF0F0, 16'hFF00};
    for (int j = 0; j < N_OUT; j++) mlut[j] = pat[j % 4];
    qf.delete();
    qs.delete();
    hs = 0;
    phase = 0;
    sticky = 1'b0;
  endtask

  always @(negedge clk) begin
    logic           exp_ov, exp_ir, empty_now;
    logic [15:0]    exp_cnt;
    logic [3:0]     exp_scnt;
    logic           is_const;
    if (armed) begin
      exp_ov   = (qs.size() > 0) && (qs[0] + 2 <= cyc);
      exp_ir   = (phase == 0) && !cfg_we && (qs.size() < 2 || out_ready);
      exp_cnt  = (hs > 65535) ? 16'hFFFF : 16'(hs);
      exp_scnt = (hs > 15) ? 4'hF : 4'(hs);
      exp_cnt[15]  = exp_cnt[15]  | sticky;
      exp_scnt[3]  = exp_scnt[3]  | sticky;
      check("out_valid", out_valid, exp_ov);
      check("in_ready", in_ready, exp_ir);
      check("busy", busy, phase != 0);
      check("cfg_ack", cfg_ack, phase == 2);
      check("eval_cnt", eval_cnt, exp_cnt);
      check("s_out_valid", s_out_valid, exp_ov);
      check("s_in_ready", s_in_ready, exp_ir);
      check("s_busy", s_busy, phase != 0);
      check("s_cfg_ack", s_cfg_ack, phase == 2);
      check("s_eval_cnt", s_eval_cnt, exp_scnt);
      if (exp_ov) begin
        check("f", f, qf[0]);
        check("s_f", s_f, qf[0]);
      end
    end else begin
      exp_ov = 1'b0;
      exp_ir = 1'b0;
    end

    if (rst) begin
      model_reset();
      armed = 1'b1;
    end else if (armed) begin
      empty_now = (qs.size() == 0);
      if (exp_ov && out_ready) begin
        void'(qf.pop_front());
        void'(qs.pop_front());
        hs++;
      end
      if (phase == 2) begin
        is_const = 1'b0;
`ifdef CCG_LUT_PARITY_EN
        is_const = (lat_data == 16'h0000) || (lat_data == 16'hFFFF);
`endif
        if (lat_idx < N_OUT && !is_const) mlut[lat_idx] = lat_data;
        if (lat_idx < N_OUT && is_const) sticky = 1'b1;
        phase = 0;
      end else if (phase == 1 && empty_now) begin
        phase = 2;
      end else if (phase == 0 && cfg_we) begin
        lat_idx  = cfg_idx;
        lat_data = cfg_data;
        phase    = 1;
      end
      if (exp_ir && in_valid) begin
        qf.push_back(model_eval(x));
        qs.push_back(cyc);
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    x = v;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    @(negedge clk);
    while (!cfg_ack && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cfg_ack_seen", cfg_ack, 1);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic [15:0] d);
    cfg_we = 1'b1;
    cfg_idx = idx;
    cfg_data = d;
    tick();
    cfg_idx = 4'($urandom);
    cfg_data = 16'($urandom);
    wait_ack();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int acc;
    logic [F_W-1:0] tmp;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_cfg_ack", cfg_ack, 0);
    check("rst_eval_cnt", eval_cnt, 0);
    check("rst_f", f, 0);
    check("rst_busy", busy, 0);

    // model pins against hand-computed tables
`ifdef CCG_LUT_PARITY_EN
    check("pin_x5", model_eval(4'h5), 16'h5555);
    check("pin_x3", model_eval(4'h3), 16'h3333);
    check("pin_xF", model_eval(4'hF), 16'hFFFF);
`else
    check("pin_x5", model_eval(4'h5), 15'h5555);
    check("pin_x3", model_eval(4'h3), 15'h3333);
    check("pin_xF", model_eval(4'hF), 15'h7FFF);
`endif
    tick();

    // stream all 16 inputs at full rate
    out_ready = 1'b1;
    for (int v = 0; v < 16; v++) send(4'(v));
    repeat (4) tick();
    @(negedge clk);
    check("t1_eval_cnt", eval_cnt, 16);
    tick();

    // reprogram LUT0 with vectors in flight
    send(4'h1);
    send(4'h2);
    send(4'h3);
    cfg_write(4'd0, 16'h00FF);
    check("pin_lut0_new", mlut[0], 16'h00FF);
    tmp = model_eval(4'h3);
    check("pin_new_x3_f0", tmp[0], 1);
    tmp = model_eval(4'h8);
    check("pin_new_x8_f0", tmp[0], 0);
    send(4'h3);
    send(4'h8);
    repeat (4) tick();

    // backpressure: only two vectors fit
    out_ready = 1'b0;
    in_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      x = 4'($urandom);
      @(negedge clk);
      if (in_ready) acc++;
      tick();
    end
    check("t3_accepts", acc, 2);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    // cfg and vector offered together; out-of-range index is dropped
    in_valid = 1'b1;
    x = 4'h7;
    cfg_we = 1'b1;
    cfg_idx = 4'd15;
    cfg_data = 16'h1234;
    @(negedge clk);
    check("t4_in_ready", in_ready, 0);
    tick();
    check("t4_busy", busy, 1);
    cfg_idx = 4'($urandom);
    wait_ack();
    send(4'h7);
    repeat (3) tick();

`ifdef CCG_LUT_PARITY_EN
    cfg_write(4'd2, 16'h0000);
    repeat (2) tick();
`endif

    // random traffic with occasional reconfiguration
    for (int c = 0; c < 600; c++) begin
      logic drop;
      in_valid  = ($urandom % 4) != 0;
      x         = 4'($urandom);
      out_ready = ($urandom % 3) != 0;
      if (cfg_we) begin
        cfg_idx  = 4'($urandom);
        cfg_data = 16'($urandom);
      end else if ($urandom % 30 == 0) begin
        cfg_we   = 1'b1;
        cfg_idx  = 4'($urandom);
        cfg_data = 16'($urandom);
      end
      @(negedge clk);
      drop = cfg_we && cfg_ack;
      tick();
      if (drop) cfg_we = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (cfg_we) wait_ack();
    repeat (4) tick();
    @(negedge clk);
    check("t5_small_sat", s_eval_cnt[2:0], 3'h7);
    tick();

    // reset while draining
    out_ready = 1'b0;
    send(4'h1);
    send(4'h2);
    cfg_we = 1'b1;
    cfg_idx = 4'd0;
    cfg_data = 16'h0000;
    tick();
    cfg_we = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("t6_busy", busy, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_out_valid", out_valid, 0);
    check("t6_busy_clr", busy, 0);
    check("t6_cnt", eval_cnt, 0);
    out_ready = 1'b1;
    send(4'h1);
    tick();
    @(negedge clk);
    check("t6_ov", out_valid, 1);
    check("t6_lut0_buf", f[0], 1);
    repeat (3) tick();

`ifdef CCG_LUT_PARITY_EN
    send(4'hF);
    tick();
    @(negedge clk);
    check("t7_parity", f[N_OUT], 1);
    repeat (3) tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
